// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the coordinate/output types shared
// between the sync generator and the downstream renderer.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_VIS    = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_VIS    = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_SYNC_POL = 1'b0;

  function automatic int span_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = span_total(DEF_H_VIS, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = span_total(DEF_V_VIS, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   pix_tick;
    logic   line_start;
    logic   frame_start;
  } vga_out_t;

endpackage

// File: rtl/pix_tick_gen.sv
// Free-running clock divider: one-clk tick every CLK_DIV system clocks.
module pix_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // With CLK_DIV=1 the counter sits at 0, which is also the terminal count.
  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  typedef logic [W-1:0] div_t;
  localparam div_t LAST = div_t'(CLK_DIV - 1);

  div_t div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                     div_cnt <= div_cnt + div_t'(1);
  end

  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters advanced by the pixel tick, with all
// outputs decoded from the counters and registered together (1 clk lag).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_VIS    = DEF_H_VIS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_VIS    = DEF_V_VIS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = DEF_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start
);

  localparam int H_TOTAL = span_total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = span_total(V_VIS, V_FP, V_SYNC, V_BP);

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS_C  = coord_t'(H_VIS);
  localparam coord_t V_VIS_C  = coord_t'(V_VIS);
  localparam coord_t HS_BEG   = coord_t'(H_VIS + H_FP);
  localparam coord_t HS_END   = coord_t'(H_VIS + H_FP + H_SYNC);
  localparam coord_t VS_BEG   = coord_t'(V_VIS + V_FP);
  localparam coord_t VS_END   = coord_t'(V_VIS + V_FP + V_SYNC);

  localparam vga_out_t OUT_RST = '{
    x:           '0,
    y:           '0,
    hsync:       ~SYNC_POL,
    vsync:       ~SYNC_POL,
    video_on:    1'b0,
    pix_tick:    1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic     tick_int;
  logic     seen_tick;
  coord_t   h_cnt;
  coord_t   v_cnt;
  vga_out_t out_d;
  vga_out_t out_q;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick_int)
  );

  // seen_tick suppresses the strobe for the (0,0) position right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      seen_tick <= 1'b0;
    end else if (tick_int) begin
      seen_tick <= 1'b1;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
      end else begin
        h_cnt <= h_cnt + coord_t'(1);
      end
    end
  end

  always_comb begin
    out_d             = OUT_RST;
    out_d.x           = h_cnt;
    out_d.y           = v_cnt;
    out_d.video_on    = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    out_d.hsync       = ((h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    out_d.vsync       = ((v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    out_d.pix_tick    = tick_int;
    // Fires on the last clk of the x=0 slot, i.e. together with its pix_tick.
    out_d.line_start  = tick_int && seen_tick && (h_cnt == '0);
    out_d.frame_start = out_d.line_start && (v_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= OUT_RST;
    else        out_q <= out_d;
  end

  assign x           = out_q.x;
  assign y           = out_q.y;
  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign video_on    = out_q.video_on;
  assign pix_tick    = out_q.pix_tick;
  assign line_start  = out_q.line_start;
  assign frame_start = out_q.frame_start;

endmodule
